// File: rtl/bmp_stream_writer.sv
// Captures one RGB888 frame (1/2/4 pixels per beat) into an internal buffer,
// then streams it out as a complete 24-bit BMP file on a byte valid/ready port.
module bmp_stream_writer #(
    parameter int WIDTH    = 768,
    parameter int HEIGHT   = 512,
    parameter int PPC      = 2,
    parameter int TOP_DOWN = 0
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             hsync,
    input  logic [8*PPC-1:0] DATA_R,
    input  logic [8*PPC-1:0] DATA_G,
    input  logic [8*PPC-1:0] DATA_B,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             Write_Done,
    output logic             drop_err
);
    localparam int WPR   = WIDTH / PPC;
    localparam int WORDS = WPR * HEIGHT;
    localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int CW    = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int RW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LW    = (PPC > 1) ? $clog2(PPC) : 1;
    localparam int PAD   = (4 - ((WIDTH * 3) % 4)) % 4;
    localparam int RB    = WIDTH * 3 + PAD;

    localparam logic [31:0] IMG_SIZE  = 32'(RB * HEIGHT);
    localparam logic [31:0] FILE_SIZE = 32'(54 + RB * HEIGHT);
    localparam logic [31:0] WIDTH_F   = 32'(WIDTH);
    localparam logic [31:0] HEIGHT_F  = (TOP_DOWN != 0) ? (32'd0 - 32'(HEIGHT)) : 32'(HEIGHT);

    // Whole header as one little-endian vector; byte n sits at bits [8n+7:8n].
    localparam logic [54*8-1:0] HDR = {128'd0, IMG_SIZE, 32'd0, 16'd24, 16'd1, HEIGHT_F,
                                       WIDTH_F, 32'd40, 32'd54, 32'd0, FILE_SIZE, 8'h4D, 8'h42};

    localparam logic [AW-1:0] BASE0 = (TOP_DOWN != 0) ? '0 : AW'((HEIGHT - 1) * WPR);

    localparam logic [1:0] ST_CAPTURE = 2'd0;
    localparam logic [1:0] ST_HEADER  = 2'd1;
    localparam logic [1:0] ST_PIXELS  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d;
    logic [5:0]    hdr_idx_q, hdr_idx_d;
    logic [AW-1:0] rd_base_q, rd_base_d;
    logic [CW-1:0] col_q, col_d;
    logic [LW-1:0] lane_q, lane_d;
    logic [1:0]    bsel_q, bsel_d;
    logic          in_pad_q, in_pad_d;
    logic [1:0]    pad_q, pad_d;
    logic [RW-1:0] row_q, row_d;
    logic          gen_done_q, gen_done_d;
    logic          valid_q, valid_d;
    logic [7:0]    data_q, data_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          drop_q, drop_d;

    logic [24*PPC-1:0] mem [WORDS];
    logic [24*PPC-1:0] wr_word;
    logic [24*PPC-1:0] rd_word;
    logic [23:0]       pix;
    logic              wr_en;
    logic              load;
    logic              row_end;
    logic              last_row;
    logic [7:0]        nxt_byte;

    always_comb begin
        wr_word = '0;
        for (int k = 0; k < PPC; k++) begin
            wr_word[24*k +: 24] = {DATA_R[8*k +: 8], DATA_G[8*k +: 8], DATA_B[8*k +: 8]};
        end
    end

    assign wr_en = hsync && (state_q == ST_CAPTURE) && !HRESET;

    // Buffer holds one beat per word, raster order; no reset on contents.
    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            mem[wr_addr_q] <= wr_word;
        end
    end

    always_comb begin
        rd_word = mem[rd_base_q + AW'(col_q)];
        pix     = rd_word[23:0];
        for (int k = 1; k < PPC; k++) begin
            if (lane_q == LW'(k)) pix = rd_word[24*k +: 24];
        end
        last_row = (row_q == RW'(HEIGHT - 1));
        row_end  = in_pad_q ? (pad_q == 2'(PAD - 1))
                            : ((bsel_q == 2'd2) && (lane_q == LW'(PPC - 1)) &&
                               (col_q == CW'(WPR - 1)) && (PAD == 0));
        nxt_byte = 8'h00;
        if (state_q == ST_HEADER) begin
            nxt_byte = HDR[{hdr_idx_q, 3'b000} +: 8];
        end else if (!in_pad_q) begin
            case (bsel_q)
                2'd0:    nxt_byte = pix[7:0];
                2'd1:    nxt_byte = pix[15:8];
                default: nxt_byte = pix[23:16];
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_addr_d  = wr_addr_q;
        hdr_idx_d  = hdr_idx_q;
        rd_base_d  = rd_base_q;
        col_d      = col_q;
        lane_d     = lane_q;
        bsel_d     = bsel_q;
        in_pad_d   = in_pad_q;
        pad_d      = pad_q;
        row_d      = row_q;
        gen_done_d = gen_done_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        done_d     = 1'b0;
        drop_d     = drop_q | (hsync && (state_q != ST_CAPTURE));

        // The output register refills whenever it is empty or being drained.
        load = (state_q != ST_CAPTURE) && !gen_done_q && (!valid_q || out_ready);
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
        end
        if (load) begin
            valid_d = 1'b1;
            data_d  = nxt_byte;
            last_d  = (state_q == ST_PIXELS) && row_end && last_row;
        end

        unique case (state_q)
            ST_CAPTURE: begin
                if (hsync) begin
                    if (wr_addr_q == AW'(WORDS - 1)) begin
                        wr_addr_d  = '0;
                        state_d    = ST_HEADER;
                        hdr_idx_d  = '0;
                        rd_base_d  = BASE0;
                        col_d      = '0;
                        lane_d     = '0;
                        bsel_d     = '0;
                        in_pad_d   = 1'b0;
                        pad_d      = '0;
                        row_d      = '0;
                        gen_done_d = 1'b0;
                    end else begin
                        wr_addr_d = wr_addr_q + AW'(1);
                    end
                end
            end
            ST_HEADER: begin
                if (load) begin
                    if (hdr_idx_q == 6'd53) begin
                        state_d   = ST_PIXELS;
                        hdr_idx_d = '0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + 6'd1;
                    end
                end
            end
            ST_PIXELS: begin
                if (load) begin
                    if (in_pad_q) begin
                        if (!row_end) pad_d = pad_q + 2'd1;
                    end else if (bsel_q != 2'd2) begin
                        bsel_d = bsel_q + 2'd1;
                    end else begin
                        bsel_d = 2'd0;
                        if (lane_q != LW'(PPC - 1)) begin
                            lane_d = lane_q + LW'(1);
                        end else begin
                            lane_d = '0;
                            if (col_q != CW'(WPR - 1)) begin
                                col_d = col_q + CW'(1);
                            end else begin
                                col_d = '0;
                                if (PAD != 0) in_pad_d = 1'b1;
                            end
                        end
                    end
                    if (row_end) begin
                        in_pad_d = 1'b0;
                        pad_d    = '0;
                        if (last_row) begin
                            gen_done_d = 1'b1;
                        end else begin
                            row_d     = row_q + RW'(1);
                            rd_base_d = (TOP_DOWN != 0) ? (rd_base_q + AW'(WPR))
                                                        : (rd_base_q - AW'(WPR));
                        end
                    end
                end
                if (valid_q && out_ready && last_q) begin
                    state_d    = ST_CAPTURE;
                    gen_done_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
            default: state_d = ST_CAPTURE;
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q    <= ST_CAPTURE;
            wr_addr_q  <= '0;
            hdr_idx_q  <= '0;
            rd_base_q  <= '0;
            col_q      <= '0;
            lane_q     <= '0;
            bsel_q     <= '0;
            in_pad_q   <= 1'b0;
            pad_q      <= '0;
            row_q      <= '0;
            gen_done_q <= 1'b0;
            valid_q    <= 1'b0;
            data_q     <= 8'h00;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_addr_q  <= wr_addr_d;
            hdr_idx_q  <= hdr_idx_d;
            rd_base_q  <= rd_base_d;
            col_q      <= col_d;
            lane_q     <= lane_d;
            bsel_q     <= bsel_d;
            in_pad_q   <= in_pad_d;
            pad_q      <= pad_d;
            row_q      <= row_d;
            gen_done_q <= gen_done_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
        end
    end

    assign in_ready   = (state_q == ST_CAPTURE);
    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign out_last   = last_q;
    assign Write_Done = done_q;
    assign drop_err   = drop_q;

endmodule

// File: tb/tb_bmp_stream_writer.sv
// Directed bench for bmp_stream_writer: a 3x2 PPC=1 bottom-up instance and a
// 4x2 PPC=2 top-down instance, both sharing clock, reset and out_ready.
module tb_bmp_stream_writer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        hs0, hs1;
    logic [7:0]  r0, g0, b0;
    logic [15:0] r1, g1, b1;
    logic        ordy;
    logic        rdy0, ov0, ol0, wd0, de0;
    logic        rdy1, ov1, ol1, wd1, de1;
    logic [7:0]  od0, od1;

    bmp_stream_writer #(.WIDTH(3), .HEIGHT(2), .PPC(1), .TOP_DOWN(0)) u_dut0 (
        .HCLK(clk), .HRESET(rst), .hsync(hs0), .DATA_R(r0), .DATA_G(g0), .DATA_B(b0),
        .in_ready(rdy0), .out_data(od0), .out_valid(ov0), .out_ready(ordy),
        .out_last(ol0), .Write_Done(wd0), .drop_err(de0));

    bmp_stream_writer #(.WIDTH(4), .HEIGHT(2), .PPC(2), .TOP_DOWN(1)) u_dut1 (
        .HCLK(clk), .HRESET(rst), .hsync(hs1), .DATA_R(r1), .DATA_G(g1), .DATA_B(b1),
        .in_ready(rdy1), .out_data(od1), .out_valid(ov1), .out_ready(ordy),
        .out_last(ol1), .Write_Done(wd1), .drop_err(de1));

    bit         sel;
    logic [7:0] m_od;
    logic       m_ov, m_ol, m_wd, m_rdy;
    assign m_od  = sel ? od1 : od0;
    assign m_ov  = sel ? ov1 : ov0;
    assign m_ol  = sel ? ol1 : ol0;
    assign m_wd  = sel ? wd1 : wd0;
    assign m_rdy = sel ? rdy1 : rdy0;

    int total = 0;
    int bad   = 0;

    logic [7:0] got   [0:199];
    logic       gl    [0:199];
    logic [7:0] exp_b [0:199];
    int   n_got, stall_bad, cyc_first, cyc_last;
    bit   timed_out;
    logic wd_a, rdy_a, wd_b;
    int   errs, fi;

    function automatic logic [7:0] pr0(input int s, input int r, input int c);
        return 8'(16 * r + c + s);
    endfunction
    function automatic logic [7:0] pg0(input int s);
        return 8'(8'h80 ^ 8'(s));
    endfunction
    function automatic logic [7:0] pb0(input int s);
        return 8'(255 - s);
    endfunction
    function automatic logic [7:0] pr1(input int r, input int c);
        return 8'(17 * (c + 1) + 128 * r);
    endfunction
    function automatic logic [7:0] pg1(input int r, input int c);
        return 8'(4 * r + c);
    endfunction
    function automatic logic [7:0] pb1(input int c);
        return 8'(64 + c);
    endfunction

    // Expected file: literal header for the 3x2 / 4x2 geometries, then rows.
    task automatic build_exp(input bit which, input int s);
        logic [7:0] h [0:53];
        int k, row;
        h = '{0: 8'h42, 1: 8'h4D, 2: 8'h4E, 10: 8'h36, 14: 8'h28, 18: 8'h03, 22: 8'h02,
              26: 8'h01, 28: 8'h18, 34: 8'h18, default: 8'h00};
        if (which) begin
            h[18] = 8'h04; h[22] = 8'hFE; h[23] = 8'hFF; h[24] = 8'hFF; h[25] = 8'hFF;
        end
        for (int i = 0; i < 54; i++) exp_b[i] = h[i];
        k = 54;
        for (int i = 0; i < 2; i++) begin
            row = which ? i : 1 - i;
            for (int c = 0; c < (which ? 4 : 3); c++) begin
                exp_b[k]     = which ? pb1(c) : pb0(s);
                exp_b[k + 1] = which ? pg1(row, c) : pg0(s);
                exp_b[k + 2] = which ? pr1(row, c) : pr0(s, row, c);
                k += 3;
            end
            if (!which) begin
                exp_b[k] = 8'h00; exp_b[k + 1] = 8'h00; exp_b[k + 2] = 8'h00;
                k += 3;
            end
        end
    endtask

    task automatic send0(input int s);
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                hs0 = 1'b1; r0 = pr0(s, r, c); g0 = pg0(s); b0 = pb0(s);
                @(posedge clk); #1;
            end
        end
        hs0 = 1'b0;
    endtask

    task automatic send1();
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 4; c += 2) begin
                hs1 = 1'b1;
                r1 = {pr1(r, c + 1), pr1(r, c)};
                g1 = {pg1(r, c + 1), pg1(r, c)};
                b1 = {pb1(c + 1), pb1(c)};
                @(posedge clk); #1;
            end
        end
        hs1 = 1'b0;
    endtask

    // Gathers one file from the selected instance; optionally pokes hsync in
    // the header and/or starts the next dut0 frame on the Write_Done cycle.
    task automatic collect(input bit bp, input bit inject_drop, input bit chain, input int chain_seed);
        bit got_last, stalled, dropped;
        logic [7:0] held;
        for (int i = 0; i < 200; i++) begin got[i] = 'x; gl[i] = 'x; end
        n_got = 0; stall_bad = 0; cyc_first = -1; cyc_last = -1;
        got_last = 0; stalled = 0; dropped = 0; held = 8'h00;
        ordy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
        for (int cyc = 0; cyc < 600 && !got_last; cyc++) begin
            @(negedge clk);
            if (stalled && (!m_ov || m_od !== held)) stall_bad++;
            stalled = 0;
            if (m_ov && ordy) begin
                if (cyc_first < 0) cyc_first = cyc;
                cyc_last = cyc;
                if (n_got < 200) begin got[n_got] = m_od; gl[n_got] = m_ol; end
                n_got++;
                if (m_ol) got_last = 1;
            end else if (m_ov) begin
                stalled = 1;
                held = m_od;
            end
            @(posedge clk); #1;
            ordy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            hs0 = 1'b0;
            if (inject_drop && !dropped && n_got == 5) begin hs0 = 1'b1; dropped = 1; end
        end
        timed_out = !got_last;
        wd_a = m_wd;
        rdy_a = m_rdy;
        wd_b = 1'bx;
        if (chain) send0(chain_seed);
        else begin
            @(posedge clk); #1;
            wd_b = m_wd;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; hs0 = 1'b0; hs1 = 1'b0; ordy = 1'b1; sel = 0;
        r0 = 0; g0 = 0; b0 = 0; r1 = 0; g1 = 0; b1 = 0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", rdy0); end
        total++; if (ov0 !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", ov0); end
        total++; if (ol0 !== 1'b0) begin bad++; $display("FAIL rst_out_last: got %b want 0", ol0); end
        total++; if (od0 !== 8'h00) begin bad++; $display("FAIL rst_out_data: got %h want 00", od0); end
        total++; if (wd0 !== 1'b0) begin bad++; $display("FAIL rst_write_done: got %b want 0", wd0); end
        total++; if (de0 !== 1'b0) begin bad++; $display("FAIL rst_drop_err: got %b want 0", de0); end
        total++; if (rdy1 !== 1'b1 || ov1 !== 1'b0) begin bad++; $display("FAIL rst_dut1: got rdy=%b valid=%b want 1 0", rdy1, ov1); end
        rst = 1'b0;
    endtask

    task automatic test_header();
        sel = 0;
        build_exp(0, 0);
        send0(0);
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL hdr_in_ready_fall: got %b want 0", rdy0); end
        @(posedge clk); #1;
        total++; if (ov0 !== 1'b1 || od0 !== 8'h42) begin bad++; $display("FAIL hdr_latency: got valid=%b data=%h want 1 42", ov0, od0); end
        collect(0, 0, 0, 0);
        total++; if (timed_out || n_got !== 78) begin bad++; $display("FAIL hdr_count: got %0d bytes want 78", n_got); end
        errs = 0; fi = 0;
        for (int i = 0; i < 78; i++) if (got[i] !== exp_b[i] || gl[i] !== (i == 77)) begin if (errs == 0) fi = i; errs++; end
        total++; if (errs != 0) begin bad++; $display("FAIL hdr_stream: %0d bytes differ, first @%0d got %h last=%b want %h", errs, fi, got[fi], gl[fi], exp_b[fi]); end
        total++; if ({got[5], got[4], got[3], got[2]} !== 32'h0000004E) begin bad++; $display("FAIL hdr_file_size: got %h want 0000004e", {got[5], got[4], got[3], got[2]}); end
        total++; if ({got[37], got[36], got[35], got[34]} !== 32'h00000018) begin bad++; $display("FAIL hdr_img_size: got %h want 00000018", {got[37], got[36], got[35], got[34]}); end
        total++; if ({got[54], got[55], got[56], got[63], got[64], got[65]} !== 48'hFF8010_000000) begin bad++; $display("FAIL hdr_row1_first: got %h want ff8010000000", {got[54], got[55], got[56], got[63], got[64], got[65]}); end
        total++; if (cyc_last - cyc_first + 1 !== 78) begin bad++; $display("FAIL hdr_no_bubbles: got %0d cycles want 78", cyc_last - cyc_first + 1); end
        total++; if (wd_a !== 1'b1 || rdy_a !== 1'b1) begin bad++; $display("FAIL hdr_done: got wd=%b rdy=%b want 1 1", wd_a, rdy_a); end
        total++; if (wd_b !== 1'b0) begin bad++; $display("FAIL hdr_done_pulse: got %b want 0", wd_b); end
    endtask

    task automatic test_lane_topdown();
        sel = 1;
        build_exp(1, 0);
        send1();
        collect(0, 0, 0, 0);
        total++; if (timed_out || n_got !== 78) begin bad++; $display("FAIL lane_count: got %0d bytes want 78", n_got); end
        errs = 0; fi = 0;
        for (int i = 0; i < 78; i++) if (got[i] !== exp_b[i] || gl[i] !== (i == 77)) begin if (errs == 0) fi = i; errs++; end
        total++; if (errs != 0) begin bad++; $display("FAIL lane_stream: %0d bytes differ, first @%0d got %h want %h", errs, fi, got[fi], exp_b[fi]); end
        total++; if ({got[25], got[24], got[23], got[22]} !== 32'hFFFFFFFE) begin bad++; $display("FAIL td_height: got %h want fffffffe", {got[25], got[24], got[23], got[22]}); end
        total++; if (got[56] !== 8'h11 || got[59] !== 8'h22) begin bad++; $display("FAIL lane_order: got %h %h want 11 22", got[56], got[59]); end
        total++; if (wd_a !== 1'b1 || wd_b !== 1'b0) begin bad++; $display("FAIL lane_done: got %b %b want 1 0", wd_a, wd_b); end
        sel = 0;
    endtask

    task automatic test_backpressure();
        sel = 0;
        build_exp(0, 5);
        send0(5);
        collect(1, 0, 0, 0);
        total++; if (timed_out || n_got !== 78) begin bad++; $display("FAIL bp_count: got %0d bytes want 78", n_got); end
        errs = 0; fi = 0;
        for (int i = 0; i < 78; i++) if (got[i] !== exp_b[i] || gl[i] !== (i == 77)) begin if (errs == 0) fi = i; errs++; end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_stream: %0d bytes differ, first @%0d got %h want %h", errs, fi, got[fi], exp_b[fi]); end
        total++; if (stall_bad !== 0) begin bad++; $display("FAIL bp_stall_hold: got %0d unstable stalls want 0", stall_bad); end
        total++; if (wd_a !== 1'b1 || wd_b !== 1'b0) begin bad++; $display("FAIL bp_done_pulse: got %b %b want 1 0", wd_a, wd_b); end
        ordy = 1'b1;
    endtask

    task automatic test_drop_back_to_back();
        sel = 0;
        build_exp(0, 7);
        send0(7);
        collect(0, 1, 1, 9);
        total++; if (timed_out || n_got !== 78) begin bad++; $display("FAIL drop_count: got %0d bytes want 78", n_got); end
        errs = 0; fi = 0;
        for (int i = 0; i < 78; i++) if (got[i] !== exp_b[i] || gl[i] !== (i == 77)) begin if (errs == 0) fi = i; errs++; end
        total++; if (errs != 0) begin bad++; $display("FAIL drop_stream: %0d bytes differ, first @%0d got %h want %h", errs, fi, got[fi], exp_b[fi]); end
        total++; if (de0 !== 1'b1) begin bad++; $display("FAIL drop_err_set: got %b want 1", de0); end
        total++; if (wd_a !== 1'b1 || rdy_a !== 1'b1) begin bad++; $display("FAIL b2b_done: got wd=%b rdy=%b want 1 1", wd_a, rdy_a); end
        build_exp(0, 9);
        collect(0, 0, 0, 0);
        total++; if (timed_out || n_got !== 78) begin bad++; $display("FAIL b2b_count: got %0d bytes want 78", n_got); end
        errs = 0; fi = 0;
        for (int i = 0; i < 78; i++) if (got[i] !== exp_b[i] || gl[i] !== (i == 77)) begin if (errs == 0) fi = i; errs++; end
        total++; if (errs != 0) begin bad++; $display("FAIL b2b_stream: %0d bytes differ, first @%0d got %h want %h", errs, fi, got[fi], exp_b[fi]); end
        total++; if (de0 !== 1'b1) begin bad++; $display("FAIL drop_err_sticky: got %b want 1", de0); end
    endtask

    task automatic test_reset_mid();
        int  cnt;
        bit  found;
        sel = 0; ordy = 1'b1;
        send0(11);
        cnt = 0; found = 0;
        for (int cyc = 0; cyc < 300 && !found; cyc++) begin
            @(negedge clk);
            if (ov0 && cnt == 64) found = 1;
            else if (ov0 && ordy) cnt++;
        end
        total++; if (!found) begin bad++; $display("FAIL rmid_reach: got %0d bytes want 64", cnt); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (ov0 !== 1'b0 || ol0 !== 1'b0) begin bad++; $display("FAIL rmid_valid: got valid=%b last=%b want 0 0", ov0, ol0); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rmid_in_ready: got %b want 1", rdy0); end
        total++; if (de0 !== 1'b0) begin bad++; $display("FAIL rmid_drop_err: got %b want 0", de0); end
        build_exp(0, 13);
        send0(13);
        collect(0, 0, 0, 0);
        total++; if (timed_out || n_got !== 78) begin bad++; $display("FAIL rmid_count: got %0d bytes want 78", n_got); end
        errs = 0; fi = 0;
        for (int i = 0; i < 78; i++) if (got[i] !== exp_b[i] || gl[i] !== (i == 77)) begin if (errs == 0) fi = i; errs++; end
        total++; if (errs != 0) begin bad++; $display("FAIL rmid_stream: %0d bytes differ, first @%0d got %h want %h", errs, fi, got[fi], exp_b[fi]); end
    endtask

    initial begin
        test_reset();
        test_header();
        test_lane_topdown();
        test_backpressure();
        test_drop_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d", total);
        $fatal(1);
    end

endmodule
